// File: rtl/tx_ts_queue_ctrl.sv
// tx_ts_queue_ctrl: two-step egress timestamp capture and FIFO queue for register-block readout
module tx_ts_queue_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          tx_clk,
  input  logic          tx_rst_n,
  input  logic          tx_clk_en_i,
  input  logic [31:0]   tsu_cfg_i,
  input  logic          sfd_ts_valid_i,
  input  logic [79:0]   sfd_ts_i,
  input  logic          frame_end_i,
  input  logic          is_ptp_message_i,
  input  logic [3:0]    ptp_messageType_i,
  input  logic [15:0]   ptp_flagField_i,
  input  logic [15:0]   ptp_sequenceId_i,
  input  logic          rd_req_i,
  input  logic          ovf_clr_i,
  output logic          rd_valid_o,
  output logic [99:0]   rd_data_o,
  output logic [AW:0]   ts_count_o,
  output logic [7:0]    ovf_cnt_o,
  output logic [7:0]    miss_cnt_o,
  output logic          ts_irq_o
);
  typedef enum logic {IDLE, WAIT_END} state_t;
  state_t state, state_nxt;
  logic q_en, qual, ts_load, push_set, miss_inc;
  logic [79:0] ts_hold;
  logic push_req;
  logic [99:0] push_data;
  logic [99:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, do_pop, do_push, ovf_inc;
  logic unused_bits;
  assign unused_bits = ^{tsu_cfg_i[31:8], tsu_cfg_i[6:2], ptp_flagField_i[15:10], ptp_flagField_i[8:0]};
  assign q_en = tsu_cfg_i[1];
  assign qual = q_en & is_ptp_message_i & ~ptp_messageType_i[3] & (~tsu_cfg_i[0] | ptp_flagField_i[9]);
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = q_en & rd_req_i & (count != '0);
  assign do_push = q_en & push_req & (~full | do_pop);
  assign ovf_inc = q_en & push_req & full & ~do_pop;
  assign ts_count_o = count;
  always_ff @(posedge tx_clk or negedge tx_rst_n)
    if (!tx_rst_n) state <= IDLE;
    else state <= state_nxt;
  // frame_end is evaluated before a same-cycle SFD, so its push uses the previously held timestamp
  always_comb begin
    state_nxt = state;
    ts_load = 1'b0;
    push_set = 1'b0;
    miss_inc = 1'b0;
    if (tx_clk_en_i) begin
      push_set = (state == WAIT_END) & frame_end_i & qual;
      miss_inc = (state == IDLE) & frame_end_i & qual;
      ts_load = sfd_ts_valid_i;
      state_nxt = sfd_ts_valid_i ? WAIT_END : frame_end_i ? IDLE : state;
    end
    if (!q_en) state_nxt = IDLE;
  end
  always_ff @(posedge tx_clk)
    if (do_push) mem[wr_ptr] <= push_data;
  always_ff @(posedge tx_clk or negedge tx_rst_n)
    if (!tx_rst_n) begin
      ts_hold <= '0;
      push_req <= 1'b0;
      push_data <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o <= '0;
      ovf_cnt_o <= '0;
      miss_cnt_o <= '0;
      ts_irq_o <= 1'b0;
    end else begin
      if (ts_load) ts_hold <= sfd_ts_i;
      push_req <= push_set;
      if (push_set) push_data <= {ts_hold, ptp_sequenceId_i, ptp_messageType_i};
      rd_valid_o <= do_pop;
      if (do_pop) rd_data_o <= mem[rd_ptr];
      if (!q_en) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
      ovf_cnt_o <= ovf_clr_i ? '0 : (ovf_inc && ovf_cnt_o != 8'hff) ? ovf_cnt_o + 8'd1 : ovf_cnt_o;
      miss_cnt_o <= ovf_clr_i ? '0 : (miss_inc && miss_cnt_o != 8'hff) ? miss_cnt_o + 8'd1 : miss_cnt_o;
      ts_irq_o <= tsu_cfg_i[7] & (count != '0);
    end
endmodule
